// File: rtl/wb_regfile_pkg.sv
// Shared widths for the write-back register file and its read-bypass selector.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wb_regfile_pkg;

    localparam int XLEN             = 32;
    localparam int REG_IDX_WIDTH    = 5;
    localparam int PC_WIDTH         = 32;
    localparam int RETIRE_CNT_WIDTH = 64;

    // Where a read port takes its data from this cycle.
    typedef enum logic [1:0] {
        RD_SRC_ZERO  = 2'd0,
        RD_SRC_MEM   = 2'd1,
        RD_SRC_EX    = 2'd2,
        RD_SRC_ARRAY = 2'd3
    } rd_src_e;

    // Priority: x0 beats every bypass; MEM beats EX because MEM is the
    // value that lands in the array on a same-index collision.
    function automatic rd_src_e rd_src_sel(input logic is_x0,
                                           input logic mem_hit,
                                           input logic ex_hit);
        rd_src_e src;
        if (is_x0) begin
            src = RD_SRC_ZERO;
        end else if (mem_hit) begin
            src = RD_SRC_MEM;
        end else if (ex_hit) begin
            src = RD_SRC_EX;
        end else begin
            src = RD_SRC_ARRAY;
        end
        return src;
    endfunction

endpackage

// File: rtl/dff.sv
// Generic enable flop with synchronous active-high reset to RST_VAL.
// Latency: 1 cycle from d to q when wen is high.
// Backpressure: none; q holds whenever wen is low.
module dff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,  // rising-edge clock
    input  logic             rst,  // synchronous, active-high; wins over wen
    input  logic             wen,  // load d on the next rising edge
    input  logic [WIDTH-1:0] d,    // next value
    output logic [WIDTH-1:0] q     // registered value
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (wen) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/rf_read_bypass.sv
// One register-file read port: x0 forcing, MEM/EX write-through bypass, array fallback.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output is forced to 0 while rst is high.
module rf_read_bypass
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::XLEN,
    parameter int IDX_W  = wb_regfile_pkg::REG_IDX_WIDTH
) (
    input  logic              rst,        // reads return 0 while high
    input  logic [IDX_W-1:0]  rd_idx,     // register being read
    input  logic              ex_we,      // qualified EX-path write this cycle
    input  logic [IDX_W-1:0]  ex_idx,     // EX-path destination
    input  logic [DATA_W-1:0] ex_wdata,   // EX-path write data
    input  logic              mem_we,     // qualified MEM-path write this cycle
    input  logic [IDX_W-1:0]  mem_idx,    // MEM-path destination
    input  logic [DATA_W-1:0] mem_wdata,  // MEM-path write data
    input  logic [DATA_W-1:0] arr_rdata,  // stored array value at rd_idx
    output logic [DATA_W-1:0] rdata       // bypassed read result
);

    rd_src_e src;

    always_comb begin
        src   = rd_src_sel(rd_idx == '0,
                           mem_we && (rd_idx == mem_idx),
                           ex_we  && (rd_idx == ex_idx));
        rdata = '0;
        if (!rst) begin
            case (src)
                RD_SRC_ZERO:  rdata = '0;
                RD_SRC_MEM:   rdata = mem_wdata;
                RD_SRC_EX:    rdata = ex_wdata;
                RD_SRC_ARRAY: rdata = arr_rdata;
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: two write streams (EX, MEM), two bypassed read ports, retire trace.
// Latency: writes land at the rising edge; reads are combinational with same-cycle write-through.
// Backpressure: none; every qualified write and every valid retire is accepted each cycle.
module wb_regfile #(
    parameter int XLEN          = wb_regfile_pkg::XLEN,
    parameter int REG_IDX_WIDTH = wb_regfile_pkg::REG_IDX_WIDTH,
    parameter int PC_WIDTH      = wb_regfile_pkg::PC_WIDTH,
    parameter int CNT_WIDTH     = wb_regfile_pkg::RETIRE_CNT_WIDTH
) (
    input  logic                     clk,                // core clock
    input  logic                     rst,                // synchronous, active-high
    input  logic                     wb_valid_i,         // retiring instruction in WB
    input  logic [PC_WIDTH-1:0]      wb_pc_i,            // its PC
    input  logic [REG_IDX_WIDTH-1:0] wb_ex_rd_idx_i,     // EX-path destination
    input  logic                     wb_ex_rd_en_i,      // EX-path write request
    input  logic [XLEN-1:0]          wb_ex_rd_wdata_i,   // EX-path data
    input  logic [REG_IDX_WIDTH-1:0] wb_mem_rd_idx_i,    // MEM-path destination
    input  logic                     wb_mem_rd_en_i,     // MEM-path write request
    input  logic [XLEN-1:0]          wb_mem_rd_wdata_i,  // MEM-path (already extended) data
    input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,          // read port 1 index
    input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,          // read port 2 index
    output logic [XLEN-1:0]          rs1_rdata_o,        // read port 1 data
    output logic [XLEN-1:0]          rs2_rdata_o,        // read port 2 data
    output logic [CNT_WIDTH-1:0]     retire_cnt_o,       // retired-instruction count
    output logic [PC_WIDTH-1:0]      last_retire_pc_o    // PC of last retired instruction
);

    import wb_regfile_pkg::*;

    localparam int NUM_REGS = 1 << REG_IDX_WIDTH;

    // Writes to x0 are dropped at qualification so x0 never changes in the array.
    logic ex_we;
    logic mem_we;

    assign ex_we  = wb_valid_i & wb_ex_rd_en_i  & (wb_ex_rd_idx_i  != '0);
    assign mem_we = wb_valid_i & wb_mem_rd_en_i & (wb_mem_rd_idx_i != '0);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (ex_we) begin
            regs_d[wb_ex_rd_idx_i] = wb_ex_rd_wdata_i;
        end
        // Applied after EX so MEM wins a same-index collision.
        if (mem_we) begin
            regs_d[wb_mem_rd_idx_i] = wb_mem_rd_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_read_bypass #(
        .DATA_W (XLEN),
        .IDX_W  (REG_IDX_WIDTH)
    ) u_rs1_bypass (
        .rst       (rst),
        .rd_idx    (rs1_idx_i),
        .ex_we     (ex_we),
        .ex_idx    (wb_ex_rd_idx_i),
        .ex_wdata  (wb_ex_rd_wdata_i),
        .mem_we    (mem_we),
        .mem_idx   (wb_mem_rd_idx_i),
        .mem_wdata (wb_mem_rd_wdata_i),
        .arr_rdata (regs_q[rs1_idx_i]),
        .rdata     (rs1_rdata_o)
    );

    rf_read_bypass #(
        .DATA_W (XLEN),
        .IDX_W  (REG_IDX_WIDTH)
    ) u_rs2_bypass (
        .rst       (rst),
        .rd_idx    (rs2_idx_i),
        .ex_we     (ex_we),
        .ex_idx    (wb_ex_rd_idx_i),
        .ex_wdata  (wb_ex_rd_wdata_i),
        .mem_we    (mem_we),
        .mem_idx   (wb_mem_rd_idx_i),
        .mem_wdata (wb_mem_rd_wdata_i),
        .arr_rdata (regs_q[rs2_idx_i]),
        .rdata     (rs2_rdata_o)
    );

    // Retire trace: the counter wraps naturally at all-ones.
    logic [CNT_WIDTH-1:0] retire_cnt_q;
    logic [CNT_WIDTH-1:0] retire_cnt_d;
    logic [PC_WIDTH-1:0]  last_pc_q;

    always_comb begin
        retire_cnt_d = retire_cnt_q + CNT_WIDTH'(1);
    end

    dff #(
        .WIDTH   (CNT_WIDTH),
        .RST_VAL ('0)
    ) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .wen (wb_valid_i),
        .d   (retire_cnt_d),
        .q   (retire_cnt_q)
    );

    dff #(
        .WIDTH   (PC_WIDTH),
        .RST_VAL ('0)
    ) u_last_pc (
        .clk (clk),
        .rst (rst),
        .wen (wb_valid_i),
        .d   (wb_pc_i),
        .q   (last_pc_q)
    );

    assign retire_cnt_o     = retire_cnt_q;
    assign last_retire_pc_o = last_pc_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table plus hand sequences, scoreboard-checked per cycle.
// Latency: reads checked in the drive cycle; retire state checked one cycle after.
// Backpressure: n/a.
module tb_wb_regfile;

    localparam int CW = 8;  // narrow retire counter so the wrap is reachable

    logic            clk = 1'b0;
    logic            rst;
    logic            wb_valid_i;
    logic [31:0]     wb_pc_i;
    logic [4:0]      wb_ex_rd_idx_i;
    logic            wb_ex_rd_en_i;
    logic [31:0]     wb_ex_rd_wdata_i;
    logic [4:0]      wb_mem_rd_idx_i;
    logic            wb_mem_rd_en_i;
    logic [31:0]     wb_mem_rd_wdata_i;
    logic [4:0]      rs1_idx_i;
    logic [4:0]      rs2_idx_i;
    logic [31:0]     rs1_rdata_o;
    logic [31:0]     rs2_rdata_o;
    logic [CW-1:0]   retire_cnt_o;
    logic [31:0]     last_retire_pc_o;

    always #5 clk = ~clk;

    wb_regfile #(
        .XLEN          (32),
        .REG_IDX_WIDTH (5),
        .PC_WIDTH      (32),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wb_valid_i        (wb_valid_i),
        .wb_pc_i           (wb_pc_i),
        .wb_ex_rd_idx_i    (wb_ex_rd_idx_i),
        .wb_ex_rd_en_i     (wb_ex_rd_en_i),
        .wb_ex_rd_wdata_i  (wb_ex_rd_wdata_i),
        .wb_mem_rd_idx_i   (wb_mem_rd_idx_i),
        .wb_mem_rd_en_i    (wb_mem_rd_en_i),
        .wb_mem_rd_wdata_i (wb_mem_rd_wdata_i),
        .rs1_idx_i         (rs1_idx_i),
        .rs2_idx_i         (rs2_idx_i),
        .rs1_rdata_o       (rs1_rdata_o),
        .rs2_rdata_o       (rs2_rdata_o),
        .retire_cnt_o      (retire_cnt_o),
        .last_retire_pc_o  (last_retire_pc_o)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic        ex_en;
        logic [4:0]  ex_idx;
        logic [31:0] ex_data;
        logic        mem_en;
        logic [4:0]  mem_idx;
        logic [31:0] mem_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] exp_rs1;
        logic [31:0] exp_rs2;
    } vec_t;

    typedef struct {
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        logic [CW-1:0] cnt;
        logic [31:0]   pc;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] m_cnt;
    logic [31:0]   m_pc;

    function automatic vec_t mk(logic r, logic v, logic [31:0] pc,
                                logic ee, logic [4:0] ei, logic [31:0] ed,
                                logic me, logic [4:0] mi, logic [31:0] md,
                                logic [4:0] a, logic [4:0] b,
                                logic [31:0] ea, logic [31:0] eb);
        vec_t x;
        x.rst = r;   x.valid = v;  x.pc = pc;
        x.ex_en = ee;  x.ex_idx = ei;  x.ex_data = ed;
        x.mem_en = me; x.mem_idx = mi; x.mem_data = md;
        x.rs1 = a;   x.rs2 = b;   x.exp_rs1 = ea; x.exp_rs2 = eb;
        return x;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle: push expectations, compare at negedge, then advance the retire model.
    task automatic apply(vec_t v, string tag);
        exp_t e;
        exp_t g;
        rst               = v.rst;
        wb_valid_i        = v.valid;
        wb_pc_i           = v.pc;
        wb_ex_rd_en_i     = v.ex_en;
        wb_ex_rd_idx_i    = v.ex_idx;
        wb_ex_rd_wdata_i  = v.ex_data;
        wb_mem_rd_en_i    = v.mem_en;
        wb_mem_rd_idx_i   = v.mem_idx;
        wb_mem_rd_wdata_i = v.mem_data;
        rs1_idx_i         = v.rs1;
        rs2_idx_i         = v.rs2;
        e.rs1 = v.exp_rs1;
        e.rs2 = v.exp_rs2;
        e.cnt = m_cnt;
        e.pc  = m_pc;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: got empty queue expected one entry", tag);
        end else begin
            g = sb.pop_front();
            check({tag, " rs1"}, 64'(rs1_rdata_o), 64'(g.rs1));
            check({tag, " rs2"}, 64'(rs2_rdata_o), 64'(g.rs2));
            check({tag, " cnt"}, 64'(retire_cnt_o), 64'(g.cnt));
            check({tag, " pc"},  64'(last_retire_pc_o), 64'(g.pc));
        end
        @(posedge clk);
        if (v.rst) begin
            m_cnt = '0;
            m_pc  = '0;
        end else if (v.valid) begin
            m_cnt = m_cnt + 1'b1;
            m_pc  = v.pc;
        end
        #1;
    endtask

    vec_t tbl[13];

    initial begin
        // Main sequence from a cleared file; exp_rs* are hand-derived.
        tbl[0]  = mk(0,1,32'h100, 1,5,32'hDEADBEEF, 0,0,32'h0,        5,0,  32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(0,0,32'h0,   0,0,32'h0,        0,0,32'h0,        5,5,  32'hDEADBEEF, 32'hDEADBEEF);
        tbl[2]  = mk(0,1,32'h104, 1,7,32'h11,       1,7,32'h22,       7,7,  32'h22,       32'h22);
        tbl[3]  = mk(0,0,32'h0,   0,0,32'h0,        0,0,32'h0,        5,7,  32'hDEADBEEF, 32'h22);
        tbl[4]  = mk(0,1,32'h108, 1,0,32'h1234,     1,0,32'hFFFFFFFF, 0,0,  32'h0,        32'h0);
        tbl[5]  = mk(0,0,32'h0,   1,3,32'h55,       0,0,32'h0,        3,3,  32'h0,        32'h0);
        tbl[6]  = mk(0,0,32'h0,   0,0,32'h0,        0,0,32'h0,        3,0,  32'h0,        32'h0);
        tbl[7]  = mk(0,1,32'h10C, 1,3,32'h33,       1,4,32'h44,       4,3,  32'h44,       32'h33);
        tbl[8]  = mk(0,1,32'h110, 1,4,32'hAAAA,     0,3,32'h99,       3,4,  32'h33,       32'hAAAA);
        tbl[9]  = mk(0,0,32'h0,   0,0,32'h0,        0,0,32'h0,        4,3,  32'hAAAA,     32'h33);
        tbl[10] = mk(0,1,32'h114, 0,5,32'h6,        1,5,32'h5555,     5,31, 32'h5555,     32'h0);
        tbl[11] = mk(0,1,32'h118, 1,31,32'hF0F0F0F0,1,30,32'h0A0A0A0A,31,30, 32'hF0F0F0F0, 32'h0A0A0A0A);
        tbl[12] = mk(0,0,32'h0,   0,0,32'h0,        0,0,32'h0,        30,31, 32'h0A0A0A0A, 32'hF0F0F0F0);

        rst = 1'b1;
        wb_valid_i = 1'b0; wb_pc_i = '0;
        wb_ex_rd_en_i = 1'b0; wb_ex_rd_idx_i = '0; wb_ex_rd_wdata_i = '0;
        wb_mem_rd_en_i = 1'b0; wb_mem_rd_idx_i = '0; wb_mem_rd_wdata_i = '0;
        rs1_idx_i = '0; rs2_idx_i = '0;
        m_cnt = '0;
        m_pc  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state: every index reads 0 on both ports.
        for (int i = 0; i < 32; i++) begin
            apply(mk(0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0),
                  $sformatf("reset_rd%0d", i));
        end

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Counter up to all-ones with no writes, then the wrapping retire.
        for (int n = 0; n < 300 && m_cnt != {CW{1'b1}}; n++) begin
            apply(mk(0,1,32'h1000 + 32'(n), 0,0,32'h0, 0,0,32'h0, 0,0, 32'h0, 32'h0), "fill");
        end
        check("cnt_allones", 64'(retire_cnt_o), 64'({CW{1'b1}}));
        apply(mk(0,1,32'h80000010, 0,0,32'h0, 0,0,32'h0, 31,30, 32'hF0F0F0F0, 32'h0A0A0A0A), "wrap");
        check("wrap_cnt", 64'(retire_cnt_o), 64'h0);
        check("wrap_pc",  64'(last_retire_pc_o), 64'h80000010);
        apply(mk(0,0,32'h12345678, 1,9,32'h1, 0,0,32'h0, 5,9, 32'h5555, 32'h0), "hold0");
        apply(mk(0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 9,0, 32'h0, 32'h0), "hold1");
        check("hold_cnt", 64'(retire_cnt_o), 64'h0);
        check("hold_pc",  64'(last_retire_pc_o), 64'h80000010);

        // Reset landing on a valid write: write discarded, reads forced to 0.
        apply(mk(1,1,32'h2000, 1,9,32'h99, 1,31,32'h77, 9,5, 32'h0, 32'h0), "rst_mid");
        apply(mk(0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 9,5, 32'h0, 32'h0), "post_rst0");
        apply(mk(0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 31,30, 32'h0, 32'h0), "post_rst1");
        apply(mk(0,1,32'h3000, 1,9,32'h99, 0,0,32'h0, 9,9, 32'h99, 32'h99), "resume0");
        apply(mk(0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 9,0, 32'h99, 32'h0), "resume1");
        check("resume_cnt", 64'(retire_cnt_o), 64'h1);

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
